// File: rtl/npu_feed_ctrl_if.sv
// ---------------------------------------------------------------------------
// npu_feed_ctrl_if
//  Window stream between the line-buffer/window generator and npu_feed_ctrl.
//  One window of MAC_IN_NUM bytes moves when win_valid & win_ready are both
//  high at a rising clock edge.
//  Signals:
//    win_data   MAC_IN_NUM*DATA_WIDTH  input window
//    win_valid  1                      window valid (from the generator)
//    win_ready  1                      window accepted (from npu_feed_ctrl)
//  Modports: master = window generator, slave = npu_feed_ctrl.
// ---------------------------------------------------------------------------
interface npu_feed_ctrl_if #(
    parameter int MAC_IN_NUM = 9,
    parameter int DATA_WIDTH = 8
);
    logic [MAC_IN_NUM*DATA_WIDTH-1:0] win_data;
    logic                             win_valid;
    logic                             win_ready;

    modport master (output win_data, output win_valid, input win_ready);
    modport slave  (input win_data, input win_valid, output win_ready);
endinterface

// File: rtl/npu_feed_ctrl.sv
// ---------------------------------------------------------------------------
// npu_feed_ctrl
//  Issue side of the NPUCore MAC interface. Accepts input windows, forwards
//  them (registered) to the core, raises adder_rst when the first window of a
//  group reaches the accumulator, and captures the core's clipped output once
//  the last window of a group has passed through the post-processing stages.
//  Ports:
//    clk, rstn                clock, async active-low reset
//    cfg_start                start pulse, sampled only in IDLE
//    cfg_acc_num[7:0]         windows per output group (0 behaves as 1)
//    cfg_grp_num[15:0]        output groups per run
//    weight_ready_in          weights/bias/scale stable at the core
//    win_if (slave)           window stream: win_data / win_valid / win_ready
//    MAC_data_out             window to core MAC_data_in (zero when idle)
//    MAC_data_valid_out       to core MAC_data_valid_in
//    MAC_accumulate_num_out   latched accumulate count
//    adder_rst_out            to core adder_rst, all bits identical
//    core_result_in           core clipped output vector
//    result_data_out          captured group result, held until next strobe
//    result_valid_out         one-cycle strobe per group
//    busy                     high whenever not IDLE
//    done                     one-cycle pulse at end of run
// ---------------------------------------------------------------------------
module npu_feed_ctrl #(
    parameter int MAC_IN_NUM  = 9,
    parameter int MAC_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int ARRAY_LAT   = 12,
    parameter int POST_LAT    = 3
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cfg_start,
    input  logic [7:0]                        cfg_acc_num,
    input  logic [15:0]                       cfg_grp_num,
    input  logic                              weight_ready_in,
    npu_feed_ctrl_if.slave                    win_if,
    output logic [MAC_IN_NUM*DATA_WIDTH-1:0]  MAC_data_out,
    output logic                              MAC_data_valid_out,
    output logic [7:0]                        MAC_accumulate_num_out,
    output logic [MAC_OUT_NUM-1:0]            adder_rst_out,
    input  logic [MAC_OUT_NUM*DATA_WIDTH-1:0] core_result_in,
    output logic [MAC_OUT_NUM*DATA_WIDTH-1:0] result_data_out,
    output logic                              result_valid_out,
    output logic                              busy,
    output logic                              done
);

    // The last marker is sampled at the accept edge, walks through the array
    // and post stages, and one extra stage lines its exit up with the cycle
    // in which core_result_in holds that group's clipped vector.
    localparam int LAST_D = ARRAY_LAT + 2 + POST_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_acc_num;
    logic [7:0]           r_acc_cnt;
    logic [15:0]          r_grp_num;
    logic [15:0]          r_grp_cnt;
    logic [ARRAY_LAT-1:0] r_first_sr;
    logic [LAST_D-1:0]    r_last_sr;

    logic                 w_win_ready;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic                 w_last_grp;

    assign win_if.win_ready = w_win_ready;
    assign w_accept   = win_if.win_valid & w_win_ready;
    assign w_first    = (r_acc_cnt == 8'd0);
    assign w_last     = (r_acc_cnt == r_acc_num - 8'd1);
    assign w_last_grp = (r_grp_cnt == r_grp_num - 16'd1);
    assign MAC_accumulate_num_out = r_acc_num;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_start) w_next = (cfg_grp_num == 16'd0) ? S_DONE : S_WAIT_W;
            S_WAIT_W: if (weight_ready_in) w_next = S_RUN;
            S_RUN:    if (w_accept && w_last && w_last_grp) w_next = S_DRAIN;
            // Earlier groups may still strobe while later markers are in flight,
            // so leave only once the marker line is empty.
            S_DRAIN:  if (result_valid_out && (r_last_sr == '0)) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        w_win_ready = (r_state == S_RUN) && weight_ready_in;
    end

    // Config latch and group counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc_num <= 8'd0;
            r_grp_num <= 16'd0;
            r_acc_cnt <= 8'd0;
            r_grp_cnt <= 16'd0;
        end else if (r_state == S_IDLE) begin
            if (cfg_start) begin
                r_acc_num <= (cfg_acc_num == 8'd0) ? 8'd1 : cfg_acc_num;
                r_grp_num <= cfg_grp_num;
                r_acc_cnt <= 8'd0;
                r_grp_cnt <= 16'd0;
            end
        end else if (w_accept) begin
            if (w_last) begin
                r_acc_cnt <= 8'd0;
                r_grp_cnt <= r_grp_cnt + 16'd1;
            end else begin
                r_acc_cnt <= r_acc_cnt + 8'd1;
            end
        end
    end

    // Issue stage and marker delay lines. Non-accept cycles issue all-zero
    // data so the core accumulates zero products through any bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            MAC_data_out       <= '0;
            MAC_data_valid_out <= 1'b0;
            r_first_sr         <= '0;
            r_last_sr          <= '0;
            adder_rst_out      <= '0;
            result_valid_out   <= 1'b0;
            result_data_out    <= '0;
        end else begin
            MAC_data_out       <= w_accept ? win_if.win_data : '0;
            MAC_data_valid_out <= w_accept;
            r_first_sr         <= {r_first_sr[ARRAY_LAT-2:0], w_accept & w_first};
            r_last_sr          <= {r_last_sr[LAST_D-2:0], w_accept & w_last};
            adder_rst_out      <= {MAC_OUT_NUM{r_first_sr[ARRAY_LAT-1]}};
            result_valid_out   <= r_last_sr[LAST_D-1];
            if (r_last_sr[LAST_D-1]) result_data_out <= core_result_in;
        end
    end

endmodule

// File: tb/tb_npu_feed_ctrl.sv
module tb_npu_feed_ctrl;
    localparam int IN_W  = 72;
    localparam int OUT_W = 144;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cfg_start = 1'b0;
    logic [7:0]       cfg_acc_num = 8'd0;
    logic [15:0]      cfg_grp_num = 16'd0;
    logic             weight_ready_in = 1'b1;
    logic [IN_W-1:0]  MAC_data_out;
    logic             MAC_data_valid_out;
    logic [7:0]       MAC_accumulate_num_out;
    logic [17:0]      adder_rst_out;
    logic [OUT_W-1:0] core_result_in;
    logic [OUT_W-1:0] result_data_out;
    logic             result_valid_out;
    logic             busy;
    logic             done;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    npu_feed_ctrl_if #(.MAC_IN_NUM(9), .DATA_WIDTH(8)) win_if ();

    npu_feed_ctrl dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .cfg_start              (cfg_start),
        .cfg_acc_num            (cfg_acc_num),
        .cfg_grp_num            (cfg_grp_num),
        .weight_ready_in        (weight_ready_in),
        .win_if                 (win_if),
        .MAC_data_out           (MAC_data_out),
        .MAC_data_valid_out     (MAC_data_valid_out),
        .MAC_accumulate_num_out (MAC_accumulate_num_out),
        .adder_rst_out          (adder_rst_out),
        .core_result_in         (core_result_in),
        .result_data_out        (result_data_out),
        .result_valid_out       (result_valid_out),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: every output byte equals the low byte of the cycle count,
    // so a captured vector reveals exactly which cycle it was taken in.
    assign core_result_in = {18{cyc[7:0]}};

    typedef struct {
        int               c;
        logic [OUT_W-1:0] d;
    } res_t;

    int   rst_q[$];
    int   done_q[$];
    res_t res_q[$];

    int              t_acc = 1;
    int              t_grp = 0;
    int              m_acc = 0;
    int              m_grp = 0;
    int              n_acc = 0;
    logic            prev_acc = 1'b0;
    logic [IN_W-1:0] prev_data = '0;

    // Accept tracker: pushes expected adder_rst / result / done cycles.
    always @(negedge clk) begin
        res_t       r;
        logic [7:0] b;
        #1;
        if (rstn && win_if.win_valid && win_if.win_ready) begin
            prev_acc  = 1'b1;
            prev_data = win_if.win_data;
            n_acc++;
            if (m_acc == 0) rst_q.push_back(cyc + 13);
            if (m_acc == t_acc - 1) begin
                b   = 8'(cyc + 17);
                r.c = cyc + 18;
                r.d = {18{b}};
                res_q.push_back(r);
                m_acc = 0;
                m_grp++;
                if (m_grp == t_grp) done_q.push_back(cyc + 19);
            end else begin
                m_acc++;
            end
        end else begin
            prev_acc = 1'b0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [IN_W-1:0] exp_d;
        int              e;
        res_t            er;
        if (rstn) begin
            exp_d = prev_acc ? prev_data : '0;
            total++;
            if (MAC_data_valid_out !== prev_acc || MAC_data_out !== exp_d) begin
                bad++;
                $display("FAIL mac_out cyc=%0d got v=%0b d=%h want v=%0b d=%h",
                         cyc, MAC_data_valid_out, MAC_data_out, prev_acc, exp_d);
            end
            if (adder_rst_out != '0 || (rst_q.size() > 0 && rst_q[0] == cyc)) begin
                total++;
                if (rst_q.size() == 0) begin
                    bad++;
                    $display("FAIL adder_rst_extra cyc=%0d got %h want none", cyc, adder_rst_out);
                end else begin
                    e = rst_q.pop_front();
                    if (e != cyc || adder_rst_out !== 18'h3ffff) begin
                        bad++;
                        $display("FAIL adder_rst cyc=%0d got %h want 3ffff at cyc %0d", cyc, adder_rst_out, e);
                    end
                end
            end
            if (result_valid_out || (res_q.size() > 0 && res_q[0].c == cyc)) begin
                total++;
                if (res_q.size() == 0) begin
                    bad++;
                    $display("FAIL result_extra cyc=%0d got v=%0b want none", cyc, result_valid_out);
                end else begin
                    er = res_q.pop_front();
                    if (er.c != cyc || result_valid_out !== 1'b1 || result_data_out !== er.d) begin
                        bad++;
                        $display("FAIL result cyc=%0d got v=%0b d=%h want d=%h at cyc %0d",
                                 cyc, result_valid_out, result_data_out, er.d, er.c);
                    end
                end
            end
            if (done || (done_q.size() > 0 && done_q[0] == cyc)) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_extra cyc=%0d got %0b want none", cyc, done);
                end else begin
                    e = done_q.pop_front();
                    if (e != cyc || done !== 1'b1) begin
                        bad++;
                        $display("FAIL done cyc=%0d got %0b want 1 at cyc %0d", cyc, done, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] acc, input logic [15:0] grp);
        @(negedge clk);
        cfg_acc_num = acc;
        cfg_grp_num = grp;
        cfg_start   = 1'b1;
        t_acc = (acc == 8'd0) ? 1 : int'(acc);
        t_grp = int'(grp);
        m_acc = 0;
        m_grp = 0;
        if (grp == 16'd0) done_q.push_back(cyc + 1);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // gap=1 drives valid only every other cycle
    task automatic feed(input int n, input int gap, input logic [7:0] base, input logic [7:0] inc);
        int         got0 = n_acc;
        int         k = 0;
        int         guard = 0;
        logic [7:0] b;
        while (n_acc - got0 < n && guard < 200) begin
            @(negedge clk);
            b = base + 8'(inc * (n_acc - got0));
            win_if.win_valid = (gap == 0) || (k % 2 == 0);
            win_if.win_data  = {9{b}};
            k++;
            guard++;
            #2;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL feed_timeout got %0d accepts want %0d", n_acc - got0, n);
        end
        @(negedge clk);
        win_if.win_valid = 1'b0;
        win_if.win_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((rst_q.size() > 0 || res_q.size() > 0 || done_q.size() > 0 || busy) && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        total++;
        if (g >= 200) begin
            bad++;
            $display("FAIL %s_drain got busy=%0b pending=%0d want idle", name, busy,
                     rst_q.size() + res_q.size() + done_q.size());
        end
    endtask

    initial begin
        win_if.win_valid = 1'b0;
        win_if.win_data  = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_busy", OUT_W'(busy), '0);
        chk("rst_ready", OUT_W'(win_if.win_ready), '0);
        chk("rst_acc_num", OUT_W'(MAC_accumulate_num_out), '0);
        chk("rst_result", result_data_out, '0);

        // 1: acc=4, grp=1, all-ones windows back to back; cfg change after latch ignored
        start_run(8'd4, 16'd1);
        cfg_acc_num = 8'd2;
        chk("t1_acc_num", OUT_W'(MAC_accumulate_num_out), OUT_W'(4));
        chk("t1_busy", OUT_W'(busy), OUT_W'(1));
        feed(4, 0, 8'h01, 8'h00);
        wait_idle("t1");

        // 2: same group with bubbles
        start_run(8'd4, 16'd1);
        feed(4, 1, 8'h10, 8'h11);
        wait_idle("t2");

        // 3: acc=0 behaves as 1, three groups
        start_run(8'd0, 16'd3);
        chk("t3_acc_num", OUT_W'(MAC_accumulate_num_out), OUT_W'(1));
        feed(3, 0, 8'hA0, 8'h01);
        wait_idle("t3");

        // 4: zero groups
        start_run(8'd2, 16'd0);
        chk("t4_busy", OUT_W'(busy), OUT_W'(1));
        chk("t4_ready", OUT_W'(win_if.win_ready), '0);
        @(negedge clk);
        chk("t4_idle", OUT_W'(busy), '0);
        wait_idle("t4");

        // 5: weight_ready low for 5 cycles mid-group
        start_run(8'd4, 16'd1);
        feed(2, 0, 8'h20, 8'h01);
        weight_ready_in  = 1'b0;
        win_if.win_valid = 1'b1;
        win_if.win_data  = {9{8'h55}};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_ready", OUT_W'(win_if.win_ready), '0);
            @(negedge clk);
        end
        weight_ready_in  = 1'b1;
        win_if.win_valid = 1'b0;
        feed(2, 0, 8'h22, 8'h01);
        wait_idle("t5");

        // 6: reset mid-run, then a clean run
        start_run(8'd4, 16'd2);
        feed(3, 0, 8'h30, 8'h01);
        @(negedge clk);
        #3;
        rstn = 1'b0;
        win_if.win_valid = 1'b0;
        rst_q.delete();
        res_q.delete();
        done_q.delete();
        prev_acc = 1'b0;
        #1;
        chk("t6_busy", OUT_W'(busy), '0);
        chk("t6_mac_v", OUT_W'(MAC_data_valid_out), '0);
        chk("t6_mac_d", OUT_W'(MAC_data_out), '0);
        chk("t6_adder_rst", OUT_W'(adder_rst_out), '0);
        chk("t6_res_v", OUT_W'(result_valid_out), '0);
        chk("t6_res_d", result_data_out, '0);
        chk("t6_acc_num", OUT_W'(MAC_accumulate_num_out), '0);
        repeat (2) @(negedge clk);
        #3;
        rstn = 1'b1;
        start_run(8'd4, 16'd1);
        feed(4, 0, 8'h40, 8'h02);
        wait_idle("t6");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
